// File: rtl/fp_adder_host_link.sv
// fp_adder_host_link: serializes four operands and a setup word to the FP adder, then deserializes its result.
// Build option FP_HOST_TIMEOUT_EN bounds the wait for adder_input_rdy_in to TIMEOUT cycles and flags error_out.
module fp_adder_host_link #(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 3,
    parameter int READ_LAT   = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic [7:0]       setup_in,
    output logic             serial1_out,
    output logic             serial2_out,
    output logic             serial3_out,
    output logic             serial4_out,
    output logic             setup_serial_out,
    output logic             wr_out,
    input  logic             adder_input_rdy_in,
    output logic             output_read_out,
    input  logic             serial_in,
    output logic [WIDTH-1:0] result_out,
    output logic             result_valid_out,
    input  logic             result_ready_in,
    output logic             error_out
);

    // state    | meaning
    // IDLE     | ready for a request; operands latched on accept
    // WAIT_RDY | waiting for adder_input_rdy_in
    // SHIFT    | WIDTH cycles of operand bits with wr_out high
    // GAP      | GAP_CYCLES quiet cycles between write and read
    // RLAT     | READ_LAT cycles of read strobe before data is valid
    // READ     | WIDTH cycles sampling serial_in into the result
    // DONE     | result presented until result_ready_in
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_SHIFT, S_GAP, S_RLAT, S_READ, S_DONE
    } state_t;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int CNT_MAX = max2(max2(WIDTH, GAP_CYCLES), max2(READ_LAT, TIMEOUT));
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_WORD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_RLAT = CW'(READ_LAT - 1);
`ifdef FP_HOST_TIMEOUT_EN
    localparam logic [CW-1:0] CNT_TMO  = CW'(TIMEOUT - 1);
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d, sh_d_q, sh_d_d;
    logic [7:0]       sh_setup_q, sh_setup_d;
    logic             ser1_q, ser1_d, ser2_q, ser2_d, ser3_q, ser3_d, ser4_q, ser4_d;
    logic             ser_setup_q, ser_setup_d;
    logic             wr_q, wr_d;
    logic             read_q, read_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             req_ready_q, req_ready_d;
    logic             tx_step;
`ifdef FP_HOST_TIMEOUT_EN
    logic             error_q, error_d;
`endif

    // Every timer is a down-counter loaded with length-1; a phase ends at terminal count zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        sh_c_d      = sh_c_q;
        sh_d_d      = sh_d_q;
        sh_setup_d  = sh_setup_q;
        ser1_d      = 1'b0;
        ser2_d      = 1'b0;
        ser3_d      = 1'b0;
        ser4_d      = 1'b0;
        ser_setup_d = 1'b0;
        wr_d        = wr_q;
        read_d      = read_q;
        result_d    = result_q;
        valid_d     = valid_q;
        req_ready_d = req_ready_q;
        tx_step     = 1'b0;
`ifdef FP_HOST_TIMEOUT_EN
        error_d     = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid_in && req_ready_q) begin
                    state_d     = S_WAIT_RDY;
                    req_ready_d = 1'b0;
                    sh_a_d      = a_in;
                    sh_b_d      = b_in;
                    sh_c_d      = c_in;
                    sh_d_d      = d_in;
                    sh_setup_d  = setup_in;
`ifdef FP_HOST_TIMEOUT_EN
                    cnt_d       = CNT_TMO;
                    error_d     = 1'b0;
`endif
                end
            end
            S_WAIT_RDY: begin
                if (adder_input_rdy_in) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_WORD;
                    wr_d    = 1'b1;
                    tx_step = 1'b1;
                end
`ifdef FP_HOST_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                    error_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
`endif
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    wr_d    = 1'b0;
                    cnt_d   = CNT_GAP;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    tx_step = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_RLAT;
                    read_d  = 1'b1;
                    cnt_d   = CNT_RLAT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RLAT: begin
                if (cnt_q == '0) begin
                    state_d = S_READ;
                    cnt_d   = CNT_WORD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_READ: begin
                // Bits enter at the top so the first sample lands in bit 0 after WIDTH shifts.
                result_d = {serial_in, result_q[WIDTH-1:1]};
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    read_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                if (result_ready_in) begin
                    state_d     = S_IDLE;
                    valid_d     = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tx_step) begin
            ser4_d      = sh_a_q[0];
            ser3_d      = sh_b_q[0];
            ser2_d      = sh_c_q[0];
            ser1_d      = sh_d_q[0];
            ser_setup_d = sh_setup_q[0];
            sh_a_d      = sh_a_q >> 1;
            sh_b_d      = sh_b_q >> 1;
            sh_c_d      = sh_c_q >> 1;
            sh_d_d      = sh_d_q >> 1;
            sh_setup_d  = sh_setup_q >> 1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sh_c_q      <= '0;
            sh_d_q      <= '0;
            sh_setup_q  <= '0;
            ser1_q      <= 1'b0;
            ser2_q      <= 1'b0;
            ser3_q      <= 1'b0;
            ser4_q      <= 1'b0;
            ser_setup_q <= 1'b0;
            wr_q        <= 1'b0;
            read_q      <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            req_ready_q <= 1'b0;
`ifdef FP_HOST_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sh_c_q      <= sh_c_d;
            sh_d_q      <= sh_d_d;
            sh_setup_q  <= sh_setup_d;
            ser1_q      <= ser1_d;
            ser2_q      <= ser2_d;
            ser3_q      <= ser3_d;
            ser4_q      <= ser4_d;
            ser_setup_q <= ser_setup_d;
            wr_q        <= wr_d;
            read_q      <= read_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            req_ready_q <= req_ready_d;
`ifdef FP_HOST_TIMEOUT_EN
            error_q     <= error_d;
`endif
        end
    end

    assign req_ready_out    = req_ready_q;
    assign serial1_out      = ser1_q;
    assign serial2_out      = ser2_q;
    assign serial3_out      = ser3_q;
    assign serial4_out      = ser4_q;
    assign setup_serial_out = ser_setup_q;
    assign wr_out           = wr_q;
    assign output_read_out  = read_q;
    assign result_out       = result_q;
    assign result_valid_out = valid_q;
`ifdef FP_HOST_TIMEOUT_EN
    assign error_out        = error_q;
`else
    assign error_out        = 1'b0;
`endif

endmodule

// File: tb/tb_fp_adder_host_link.sv
// Bench for fp_adder_host_link: a behavioural serial adder checks the write burst and returns
// a chosen result; a scoreboard compares every delivered result against the expected queue.
module tb_fp_adder_host_link;

    localparam int WIDTH      = 16;
    localparam int GAP_CYCLES = 3;
    localparam int READ_LAT   = 1;
    localparam int TIMEOUT    = 64;
    localparam int LATENCY    = 1 + WIDTH + GAP_CYCLES + READ_LAT + WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] d;
        logic [7:0]       s;
    } req_t;

    logic             clk_in, rst_in;
    logic             req_valid_in, req_ready_out;
    logic [WIDTH-1:0] a_in, b_in, c_in, d_in;
    logic [7:0]       setup_in;
    logic             serial1_out, serial2_out, serial3_out, serial4_out, setup_serial_out;
    logic             wr_out, adder_input_rdy_in, output_read_out, serial_in;
    logic [WIDTH-1:0] result_out;
    logic             result_valid_out, result_ready_in, error_out;

    req_t             req_q[$];
    logic [WIDTH-1:0] resp_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               cyc      = 0;

    fp_adder_host_link #(
        .WIDTH(WIDTH), .GAP_CYCLES(GAP_CYCLES), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .setup_in(setup_in),
        .serial1_out(serial1_out), .serial2_out(serial2_out),
        .serial3_out(serial3_out), .serial4_out(serial4_out),
        .setup_serial_out(setup_serial_out), .wr_out(wr_out),
        .adder_input_rdy_in(adder_input_rdy_in), .output_read_out(output_read_out),
        .serial_in(serial_in), .result_out(result_out),
        .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
        .error_out(error_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Behavioural adder: records the write burst, checks it against the issued request,
    // then answers the read strobe with the queued response, LSB first after READ_LAT cycles.
    initial begin : adder_model
        logic [WIDTH-1:0] cap_a, cap_b, cap_c, cap_d, cap_s, rsp_sh;
        int               wr_cnt, gap_cnt, rd_cnt;
        bit               prev_wr, prev_rd, in_gap;
        req_t             rq;
        wr_cnt = 0; gap_cnt = 0; rd_cnt = 0;
        prev_wr = 0; prev_rd = 0; in_gap = 0;
        cap_a = '0; cap_b = '0; cap_c = '0; cap_d = '0; cap_s = '0; rsp_sh = '0;
        serial_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                wr_cnt = 0; rd_cnt = 0; prev_wr = 0; prev_rd = 0; in_gap = 0;
                req_q.delete();
                resp_q.delete();
                serial_in = 1'b0;
            end else begin
                if (wr_out) begin
                    if (wr_cnt < WIDTH) begin
                        cap_a = {serial4_out, cap_a[WIDTH-1:1]};
                        cap_b = {serial3_out, cap_b[WIDTH-1:1]};
                        cap_c = {serial2_out, cap_c[WIDTH-1:1]};
                        cap_d = {serial1_out, cap_d[WIDTH-1:1]};
                        cap_s = {setup_serial_out, cap_s[WIDTH-1:1]};
                    end
                    wr_cnt++;
                end else if (prev_wr) begin
                    chk("wr_len", wr_cnt, WIDTH);
                    if (req_q.size() > 0) begin
                        rq = req_q.pop_front();
                        chk("op_a", cap_a, rq.a);
                        chk("op_b", cap_b, rq.b);
                        chk("op_c", cap_c, rq.c);
                        chk("op_d", cap_d, rq.d);
                        chk("setup", cap_s, {8'h00, rq.s});
                    end else begin
                        chk("req_queue", req_q.size(), 1);
                    end
                    wr_cnt  = 0;
                    in_gap  = 1;
                    gap_cnt = 0;
                end
                if (in_gap) begin
                    if (output_read_out) begin
                        chk("gap_len", gap_cnt, GAP_CYCLES);
                        in_gap = 0;
                    end else begin
                        gap_cnt++;
                    end
                end
                if (output_read_out) begin
                    if (!prev_rd) begin
                        rsp_sh = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
                        rd_cnt = 0;
                    end
                    rd_cnt++;
                    if (rd_cnt > READ_LAT && rd_cnt <= READ_LAT + WIDTH) begin
                        serial_in = rsp_sh[0];
                        rsp_sh    = rsp_sh >> 1;
                    end else begin
                        serial_in = 1'($urandom_range(0, 1));
                    end
                end else begin
                    if (prev_rd) chk("read_len", rd_cnt, READ_LAT + WIDTH);
                    serial_in = 1'($urandom_range(0, 1));
                end
                prev_wr = wr_out;
                prev_rd = output_read_out;
            end
        end
    end

    initial forever begin : monitor
        @(negedge clk_in);
        if (rst_in && result_valid_out && result_ready_in) begin
            if (exp_q.size() == 0) chk("result_queue", exp_q.size(), 1);
            else chk("result", result_out, exp_q.pop_front());
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                        input logic [7:0] s, input logic [WIDTH-1:0] resp, output int acc);
        int   k;
        req_t rq;
        k = 0;
        while (!req_ready_out && k < 300) begin
            @(posedge clk_in); #1;
            k++;
        end
        chk("req_ready_wait", req_ready_out, 1);
        a_in = a; b_in = b; c_in = c; d_in = d; setup_in = s;
        req_valid_in = 1'b1;
        rq.a = a; rq.b = b; rq.c = c; rq.d = d; rq.s = s;
        req_q.push_back(rq);
        resp_q.push_back(resp);
        exp_q.push_back(resp);
        @(posedge clk_in); #1;
        acc = cyc;
        req_valid_in = 1'b0;
        chk("accept", req_ready_out, 0);
    endtask

    task automatic wait_valid(output int at);
        int k;
        k = 0;
        while (!result_valid_out && k < 200) begin
            @(posedge clk_in); #1;
            k++;
        end
        chk("valid_seen", result_valid_out, 1);
        at = cyc;
    endtask

    task automatic wait_drain(input bit randomize_hs);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk_in); #1;
            if (randomize_hs) begin
                adder_input_rdy_in = 1'($urandom_range(0, 1));
                result_ready_in    = 1'($urandom_range(0, 1));
            end
            k++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin : driver
        int               acc, acc2, at, n;
        logic [WIDTH-1:0] a, r;
        rst_in = 1'b0; req_valid_in = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; setup_in = '0;
        adder_input_rdy_in = 1'b0; result_ready_in = 1'b0;

        @(posedge clk_in); #1;
        chk("rst_wr", wr_out, 0);
        chk("rst_read", output_read_out, 0);
        chk("rst_valid", result_valid_out, 0);
        chk("rst_result", result_out, 0);
        chk("rst_req_ready", req_ready_out, 0);
        chk("rst_error", error_out, 0);
        chk("rst_serial", {serial1_out, serial2_out, serial3_out, serial4_out, setup_serial_out}, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("ready_after_rst", req_ready_out, 1);

        // Bus pattern, result capture and latency, then backpressure in DONE.
        adder_input_rdy_in = 1'b1;
        send(16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 8'h1E, 16'h4960, acc);
        @(posedge clk_in); #1;
        chk("wr_start", wr_out, 1);
        wait_valid(at);
        chk("latency", at - acc, LATENCY);
        chk("result_direct", result_out, 16'h4960);
        req_valid_in = 1'b1;
        a_in = 16'($urandom);
        n = 0;
        repeat (10) begin
            @(posedge clk_in); #1;
            if (result_out !== 16'h4960 || req_ready_out !== 1'b0 ||
                result_valid_out !== 1'b1 || wr_out !== 1'b0) n++;
        end
        chk("backpressure_hold", n, 0);
        req_valid_in    = 1'b0;
        result_ready_in = 1'b1;
        wait_drain(0);

        // Ready stall, with rdy dropped again during SHIFT.
        adder_input_rdy_in = 1'b0;
        send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
             16'($urandom), acc);
        n = 0;
        repeat (20) begin
            @(posedge clk_in); #1;
            if (wr_out) n++;
        end
        chk("stall_no_wr", n, 0);
        adder_input_rdy_in = 1'b1;
        @(posedge clk_in); #1;
        chk("shift_after_rdy", wr_out, 1);
        adder_input_rdy_in = 1'b0;
        wait_drain(0);
        adder_input_rdy_in = 1'b1;

        // Reset at bit 5 of SHIFT, then a clean transaction.
        a = 16'($urandom);
        send(a, 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 16'h1234, acc);
        n = 0;
        while (!wr_out && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk("rst_test_wr_seen", wr_out, 1);
        repeat (5) begin
            @(posedge clk_in); #1;
        end
        chk("bit5_a", serial4_out, a[5]);
        rst_in = 1'b0;
        exp_q.delete();
        @(posedge clk_in); #1;
        chk("midrst_wr", wr_out, 0);
        chk("midrst_serial", {serial1_out, serial2_out, serial3_out, serial4_out, setup_serial_out}, 0);
        chk("midrst_read", output_read_out, 0);
        chk("midrst_valid", result_valid_out, 0);
        rst_in = 1'b1;
        n = 0;
        repeat (45) begin
            @(posedge clk_in); #1;
            if (result_valid_out || wr_out || output_read_out) n++;
        end
        chk("post_rst_quiet", n, 0);
        send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
             16'hC900, acc);
        wait_drain(0);

        // Back-to-back with result_ready_in tied high.
        result_ready_in = 1'b1;
        send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
             16'($urandom), acc);
        send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
             16'($urandom), acc2);
        chk("b2b_accept_gap", acc2 - acc, LATENCY + 2);
        wait_drain(0);

        // Randomized traffic with random adder readiness and consumer backpressure.
        for (int i = 0; i < 10; i++) begin
            r = 16'($urandom);
            send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), r, acc);
            wait_drain(1);
        end

        adder_input_rdy_in = 1'b1;
        result_ready_in    = 1'b1;
        repeat (5) begin
            @(posedge clk_in); #1;
        end
        chk("req_queue_empty", req_q.size(), 0);
        chk("final_error", error_out, 0);
        chk("final_idle_ready", req_ready_out, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
